// File: rtl/icache_dm_if.sv
// Word-read handshake between the instruction cache and backing memory.
// master = cache side, slave = memory side.
interface icache_dm_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only I-cache: same-cycle hits, in-order line refill on miss.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module icache_dm #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcF,
    output logic [31:0] instrF,
    output logic        stall_cache,
    input  logic        flush,
`ifdef ICACHE_STATS_EN
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
`endif
    icache_dm_if.master mem
);
    localparam int OB = $clog2(WORDS);
    localparam int IB = $clog2(LINES);
    localparam int TB = 30 - OB - IB;

    typedef enum logic {IDLE, FILL} state_e;

    state_e           state_q, state_d;
    logic [OB-1:0]    cnt_q, cnt_d;
    logic [IB-1:0]    fidx_q, fidx_d;
    logic [TB-1:0]    ftag_q, ftag_d;
    logic             pflush_q, pflush_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [TB-1:0]    tag_q  [LINES];
    logic [31:0]      data_q [LINES*WORDS];

    logic [OB-1:0] off;
    logic [IB-1:0] idx;
    logic [TB-1:0] tag;
    logic          hit, ack, last;
    logic          unused_pc;

    assign off       = pcF[OB+1:2];
    assign idx       = pcF[OB+IB+1:OB+2];
    assign tag       = pcF[31:OB+IB+2];
    assign unused_pc = ^pcF[1:0];

    assign hit  = reset && (state_q == IDLE) &&
                  valid_q[idx] && (tag_q[idx] == tag);
    assign ack  = reset && (state_q == FILL) && mem.mem_ack;
    assign last = &cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (!hit) state_d = FILL;
            FILL: if (mem.mem_ack && last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        instrF         = hit ? data_q[{idx, off}] : 32'h0;
        stall_cache    = ~hit;
        mem.mem_req    = reset && (state_q == FILL);
        mem.mem_addr   = '0;
        if (mem.mem_req) mem.mem_addr = {ftag_q, fidx_q, cnt_q, 2'b00};
    end

    // A flush seen mid-fill is deferred so the line in flight still completes.
    always_comb begin
        cnt_d    = cnt_q;
        fidx_d   = fidx_q;
        ftag_d   = ftag_q;
        pflush_d = pflush_q;
        valid_d  = valid_q;
        if (state_q == IDLE) begin
            if (flush) valid_d = '0;
            if (!hit) begin
                cnt_d  = '0;
                fidx_d = idx;
                ftag_d = tag;
            end
        end else begin
            if (flush) pflush_d = 1'b1;
            if (mem.mem_ack) begin
                cnt_d = cnt_q + OB'(1);
                if (last) begin
                    pflush_d = 1'b0;
                    if (pflush_q || flush) valid_d = '0;
                    else                   valid_d[fidx_q] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q    <= '0;
            fidx_q   <= '0;
            ftag_q   <= '0;
            pflush_q <= 1'b0;
            valid_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            fidx_q   <= fidx_d;
            ftag_q   <= ftag_d;
            pflush_q <= pflush_d;
            valid_q  <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ack) begin
            data_q[{fidx_q, cnt_q}] <= mem.mem_rdata;
            if (last) tag_q[fidx_q] <= ftag_q;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit && !(&hit_cnt_q))
                hit_cnt_q <= hit_cnt_q + 32'd1;
            if (state_q == IDLE && !hit && !(&miss_cnt_q))
                miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif
endmodule

// File: tb/tb_icache_dm.sv
// Randomized scoreboard bench for icache_dm against a line-level cache model.
// Memory wait states, flushes and a mid-fill reset are all exercised.
module tb_icache_dm;
    localparam int L = 16;
    localparam int W = 4;

    typedef struct {
        logic [31:0] instr;
        int          stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pcF = '0;
    logic        flush = 1'b0;
    logic [31:0] instrF;
    logic        stall_cache;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache_dm_if mif();

    icache_dm #(.LINES(L), .WORDS(W)) dut (
        .clk(clk),
        .reset(reset),
        .pcF(pcF),
        .instrF(instrF),
        .stall_cache(stall_cache),
        .flush(flush),
`ifdef ICACHE_STATS_EN
        .hit_count(hit_count),
        .miss_count(miss_count),
`endif
        .mem(mif.master)
    );

    always #5 clk = ~clk;

    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    bit          mvalid[L];
    int          mline[L];
    int          ws = 0;
    bit          mon_en = 1'b0;
    int          compared = 0;
    int          mismatched = 0;
    int          hits_m = 0;
    int          miss_m = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h20080005;
            32'h4:   return 32'h20090007;
            32'h8:   return 32'h01095020;
            32'hC:   return 32'hAC0A0000;
            default: return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic finish_sim();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    endtask

    task automatic model_clear();
        for (int i = 0; i < L; i++) mvalid[i] = 1'b0;
    endtask

    task automatic model_fill(input int line);
        mvalid[line % L] = 1'b1;
        mline[line % L]  = line;
        miss_m++;
        for (int k = 0; k < W; k++) addr_q.push_back(32'(line * 4 * W + 4 * k));
    endtask

    // Backing memory: ack after ws wait cycles; checks request ordering and stability.
    initial begin
        int          wcnt;
        logic [31:0] held;
        wcnt = 0;
        held = '0;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mif.mem_req) begin
                if (wcnt > 0) check("addr_stable", mif.mem_addr, held);
                held = mif.mem_addr;
                if (wcnt >= ws) begin
                    if (addr_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL mem_addr: got %h expected no request", mif.mem_addr);
                    end else begin
                        check("mem_addr", mif.mem_addr, addr_q.pop_front());
                    end
                    mif.mem_ack = 1'b1;
                    mif.mem_rdata = mem_word(mif.mem_addr);
                    wcnt = 0;
                end else begin
                    mif.mem_ack = 1'b0;
                    mif.mem_rdata = $urandom;
                    wcnt++;
                end
            end else begin
                mif.mem_ack = 1'b0;
                wcnt = 0;
            end
        end
    end

    // Monitor: each stall-free cycle delivers one fetch; compare against the queue.
    initial begin
        int   scnt;
        exp_t e;
        scnt = 0;
        forever begin
            @(negedge clk);
            if (!reset || !mon_en) begin
                scnt = 0;
            end else if (stall_cache) begin
                scnt++;
            end else begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL fetch: got instr %h expected nothing", instrF);
                end else begin
                    e = exp_q.pop_front();
                    check("instrF", instrF, e.instr);
                    check("stall_cycles", 32'(scnt), 32'(e.stall));
                end
                scnt = 0;
            end
        end
    end

    task automatic do_fetch(input logic [31:0] pc, input bit fl_idle,
                            input bit fl_fill, input int w);
        int   line, cost, n;
        bit   hit, done;
        exp_t e;
        line = int'(pc / (4 * W));
        hit  = mvalid[line % L] && (mline[line % L] == line);
        cost = W * (w + 1) + 1;
        e.instr = mem_word({pc[31:2], 2'b00});
        e.stall = 0;
        if (fl_idle) model_clear();
        if (!hit) begin
            model_fill(line);
            e.stall = cost;
            if (fl_fill) begin
                model_clear();
                model_fill(line);
                e.stall += cost;
            end
        end
        hits_m++;
        exp_q.push_back(e);
        ws = w;
        pcF = pc;
        flush = fl_idle;
        mon_en = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            done = !stall_cache;
            @(posedge clk);
            #1;
            n++;
            flush = (n == 1) && !hit && fl_fill;
            if (done) break;
            if (n > 400) begin
                compared++;
                mismatched++;
                $display("FAIL timeout: pc %h still stalled after %0d cycles", pc, n);
                finish_sim();
            end
        end
    endtask

    initial begin
        model_clear();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall_cache), 32'd1);
        check("rst_instr", instrF, 32'h0);
        check("rst_req", 32'(mif.mem_req), 32'd0);
        check("rst_addr", mif.mem_addr, 32'h0);
`ifdef ICACHE_STATS_EN
        check("rst_hits", hit_count, 32'd0);
        check("rst_miss", miss_count, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;

        do_fetch(32'h0, 0, 0, 0);
        do_fetch(32'hC, 0, 0, 0);
        do_fetch(32'h100, 0, 0, 0);
        do_fetch(32'h0, 0, 0, 0);
        do_fetch(32'h204, 0, 0, 3);
        do_fetch(32'h208, 1, 0, 0);
        do_fetch(32'h0, 0, 0, 0);
        do_fetch(32'h300, 0, 1, 1);
        do_fetch(32'h304, 0, 0, 0);

        for (int i = 0; i < 250; i++)
            do_fetch(32'($urandom_range(0, 511)) << 2,
                     ($urandom % 16) == 0, ($urandom % 12) == 0,
                     int'($urandom_range(0, 2)));
        mon_en = 1'b0;
`ifdef ICACHE_STATS_EN
        check("hit_count", hit_count, 32'(hits_m));
        check("miss_count", miss_count, 32'(miss_m));
`endif

        pcF = 32'h4000;
        ws = 0;
        for (int k = 0; k < W; k++) addr_q.push_back(32'h4000 + 32'(4 * k));
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_req", 32'(mif.mem_req), 32'd0);
        check("midrst_instr", instrF, 32'h0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("postrst_req", 32'(mif.mem_req), 32'd0);
        check("postrst_stall", 32'(stall_cache), 32'd1);
        check("postrst_instr", instrF, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        addr_q.delete();
        hits_m = 0;
        miss_m = 0;

        do_fetch(32'h0, 0, 0, 0);
        do_fetch(32'h8, 0, 0, 0);
        for (int i = 0; i < 20; i++)
            do_fetch(32'($urandom_range(0, 511)) << 2, 0, 0,
                     int'($urandom_range(0, 1)));
        mon_en = 1'b0;
`ifdef ICACHE_STATS_EN
        check("hit_count_end", hit_count, 32'(hits_m));
        check("miss_count_end", miss_count, 32'(miss_m));
`endif
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("addr_q_drained", 32'(addr_q.size()), 32'd0);
        finish_sim();
    end
endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache between the pipelined core's fetch port (pcF/instrF) and a slower backing instruction memory.
- Serves hits combinationally in the same cycle.
- On a miss, raises a stall to the core and refills the whole line through a req/ack word handshake.
- Sits directly upstream of the core's Fetch stage; stall_cache is ORed into the core's stallF.

Parameters:
LINES, 16, number of cache lines; power of two, at least 2.
WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low reset.
pcF  in  32  fetch byte address from the core; bits [1:0] ignored.
instrF  out  32  instruction for pcF; valid when stall_cache=0.
stall_cache  out  1  miss in service; the core must hold pcF.
flush  in  1  invalidate all lines.
mem_req  out  1  backing-memory word read request.
mem_addr  out  32  word-aligned request address.
mem_ack  in  1  request accepted; mem_rdata is valid this cycle.
mem_rdata  in  32  read data from the backing memory.

Behaviour:
- Address split, with OB = log2(WORDS) and IB = log2(LINES):
  - offset = pcF[OB+1:2]
  - index = pcF[OB+IB+1:OB+2]
  - tag = the remaining upper bits.
  - Defaults: offset [3:2], index [7:4], tag [31:8].
- Storage: valid[LINES], tag[LINES], data[LINES*WORDS]. Only valid is reset; data and tag are not.
- Reset (reset=0 at a rising edge):
  - state=IDLE, all valid bits cleared, word counter=0, pending-flush=0.
  - mem_req=0, mem_addr=0, stall_cache=1 while reset is low.
  - instrF=0.
- hit = (state==IDLE) & valid[index] & (tag match). Combinational in the same cycle.
- Outputs:
  - instrF = data[index][offset] on a hit, else 32'h0 (a NOP).
  - stall_cache = ~hit.
- FSM states: IDLE, FILL.
  - IDLE, miss at cycle N: latch the fill tag and index from pcF, counter=0, go to FILL at N+1.
  - FILL:
    - mem_req=1, mem_addr={fill_tag, fill_index, counter, 2'b00}.
    - req and addr are held stable until mem_ack=1.
    - On ack: write mem_rdata into data[fill_index][counter] and increment the counter.
    - The next word is requested in the following cycle. mem_req stays high across consecutive words.
    - On the ack of word WORDS-1: write tag[fill_index] and set valid[fill_index] (unless a flush is pending), drop mem_req, go to IDLE.
  - Zero-wait memory: the miss costs exactly WORDS+1 stall cycles (5 for the defaults). The hit appears in the first IDLE cycle.
- mem_ack while mem_req=0 is ignored.
- Words are always fetched in order 0..WORDS-1; there is no critical-word-first.
- The fill uses the latched address. A pcF change during FILL does not affect the fill; after FILL, hit or miss is re-evaluated on the current pcF.
- flush:
  - In IDLE: all valid bits are cleared at the edge. A lookup in the same cycle as flush uses the pre-flush state.
  - During FILL: sets pending-flush. The fill completes, then all valid bits are cleared (including the filled line) and pending-flush is cleared.
- Reset mid-FILL: the fill is abandoned, mem_req=0 in the next cycle, and the cache is fully invalid.
- Conflict miss (same index, different tag): the line is overwritten; there is no writeback because the cache is read-only.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds ports hit_count (out, 32) and miss_count (out, 32), both reset to 0.
  - hit_count increments on each cycle with a hit.
  - miss_count increments once per fill started (on the IDLE-to-FILL transition).
  - Both saturate at 32'hFFFFFFFF.
  - Both are cleared by reset but not by flush.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Cold miss, zero-wait memory:
   - Stimulus: after reset, pcF=0x0; memory returns 0x20080005, 0x20090007, 0x01095020, 0xAC0A0000 with ack on every request.
   - Response: stall_cache=1 for 5 cycles; mem_addr sequence 0x0, 0x4, 0x8, 0xC; then instrF=0x20080005.
   - Follow-up: pcF=0xC gives instrF=0xAC0A0000 with no stall.
2. Conflict:
   - Stimulus: after test 1, pcF=0x100.
   - Response: miss and fill from 0x100–0x10C.
   - Follow-up: pcF=0x0 misses again and refills from 0x0.
3. Wait states:
   - Stimulus: ack asserted on the 4th cycle of each request.
   - Response: mem_addr stays stable while waiting; stall lasts 17 cycles; the data is correct.
4. Flush:
   - In IDLE: flush after test 1, then pcF=0x0 gives a miss.
   - During FILL: flush asserted in the 2nd fill cycle; the fill completes, the next cycle misses at the same pcF, and a second fill is issued.
5. Reset mid-FILL:
   - Stimulus: reset=0 during the fill of word 2.
   - Response: mem_req=0 next cycle and instrF=0; after release, pcF=0x0 starts a fresh fill at 0x0.
6. Stats (with ICACHE_STATS_EN):
   - Stimulus: test 1, then 3 consecutive hit cycles.
   - Response: miss_count=1, hit_count=3 (plus the hit in the first IDLE cycle after the fill, if pcF was held).
